// File: rtl/servo_cmd_sequencer.sv
// Servo command sequencer: debounced key capture into per-channel targets, slewed positions
// emitted round-robin once per frame. Define SERVO_SEQ_SLEW_BYPASS_EN to jump straight to target.
module servo_cmd_sequencer #(
  parameter int CLK_FREQ        = 50000000,
  parameter int UPDATE_HZ       = 50,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP            = 4,
  parameter int RESET_POS       = 128,
  parameter int DUTY_MIN        = 25,
  parameter int DUTY_MAX        = 230
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_load,
  input  logic [1:0] switch_address,
  input  logic [7:0] switch_duty_cycle,
  output logic [1:0] servo_address,
  output logic [7:0] duty_cycle,
  output logic       load,
  output logic       busy
);

  localparam int TICK_PERIOD = CLK_FREQ / UPDATE_HZ;
  localparam int TICK_W      = $clog2(TICK_PERIOD);
  localparam int DB_W        = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_PERIOD - 1);
  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]        RESET_DUTY = 8'(RESET_POS);
  localparam logic [7:0]        DMIN8      = 8'(DUTY_MIN);
  localparam logic [7:0]        DMAX8      = 8'(DUTY_MAX);
  localparam logic [7:0]        STEP8      = 8'(STEP);
  localparam logic signed [8:0] STEP_S     = 9'(STEP);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;

  function automatic logic [7:0] clamp_duty(input logic [7:0] d);
    if (d < DMIN8)      return DMIN8;
    else if (d > DMAX8) return DMAX8;
    else                return d;
  endfunction

  // 9-bit signed difference so the step never overshoots or wraps past 0/255.
  function automatic logic [7:0] slew(input logic [7:0] pos, input logic [7:0] tgt);
    logic signed [8:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, pos});
    if (diff > STEP_S)       return pos + STEP8;
    else if (diff < -STEP_S) return pos - STEP8;
    else                     return tgt;
  endfunction

  logic              key_sync_p0, key_sync_p1, key_db;
  logic [DB_W-1:0]   db_cnt;
  logic              db_flip, press;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [7:0]        pos [0:3];
  logic [7:0]        tgt [0:3];
  logic [7:0]        next_pos;
  logic [1:0]        state, ch;
  logic              pending;

  // Key synchronizer stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_sync_p0 <= 1'b1;
      key_sync_p1 <= 1'b1;
    end else begin
      key_sync_p0 <= key_load;
      key_sync_p1 <= key_sync_p0;
    end
  end

  assign db_flip = (key_sync_p1 != key_db) && (db_cnt == DB_LAST);
  assign press   = db_flip && !key_sync_p1;

  // Debounce stage: the level flips only after a full run of differing samples
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_db <= 1'b1;
      db_cnt <= '0;
    end else if (key_sync_p1 == key_db) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      key_db <= key_sync_p1;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) tgt[i] <= RESET_DUTY;
    end else if (press) begin
      tgt[switch_address] <= clamp_duty(switch_duty_cycle);
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
  end

  always_comb begin
`ifdef SERVO_SEQ_SLEW_BYPASS_EN
    next_pos = tgt[ch];
`else
    next_pos = slew(pos[ch], tgt[ch]);
`endif
  end

  // Frame scan: SETUP/STROBE pair per channel, load high only in STROBE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      ch            <= 2'd0;
      pending       <= 1'b0;
      busy          <= 1'b0;
      load          <= 1'b0;
      servo_address <= 2'd0;
      duty_cycle    <= RESET_DUTY;
      for (int i = 0; i < 4; i++) pos[i] <= RESET_DUTY;
    end else begin
      load <= 1'b0;
      if (tick && state != ST_IDLE) pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (tick || pending) begin
            state   <= ST_SETUP;
            ch      <= 2'd0;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
        end
        ST_SETUP: begin
          pos[ch]       <= next_pos;
          servo_address <= ch;
          duty_cycle    <= next_pos;
          load          <= 1'b1;
          state         <= ST_STROBE;
        end
        ST_STROBE: begin
          if (ch == 2'd3) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            ch    <= ch + 2'd1;
            state <= ST_SETUP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// Bench for servo_cmd_sequencer: strobes are logged by a monitor and scored against a
// frame-level model of targets and slewed positions (20-cycle frames, debounce 5, step 4).
module tb_servo_cmd_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_load = 1'b1;
  logic [1:0] switch_address = 2'd0;
  logic [7:0] switch_duty_cycle = 8'd0;
  logic [1:0] servo_address;
  logic [7:0] duty_cycle;
  logic       load;
  logic       busy;

  servo_cmd_sequencer #(
    .CLK_FREQ(1000), .UPDATE_HZ(50), .DEBOUNCE_CYCLES(5), .STEP(4),
    .RESET_POS(128), .DUTY_MIN(25), .DUTY_MAX(230)
  ) dut (
    .clock(clock), .reset(reset), .key_load(key_load),
    .switch_address(switch_address), .switch_duty_cycle(switch_duty_cycle),
    .servo_address(servo_address), .duty_cycle(duty_cycle),
    .load(load), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct { int addr; int duty; int gap; int t; } strobe_t;
  typedef struct { int t; int a; int v; } cap_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_strobe = 0;
  int busy_len = 0;
  logic prev_busy = 1'b0;
  strobe_t sq[$];
  int busy_q[$];
  cap_t cap_q[$];
  int m_pos[4];
  int m_tgt[4];
  int m_ch;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (!reset) begin
      busy_len = 0;
      prev_busy = 1'b0;
    end else begin
      if (load) begin
        sq.push_back('{int'(servo_address), int'(duty_cycle), cyc - last_strobe, cyc});
        last_strobe = cyc;
      end
      if (busy) busy_len++;
      else if (prev_busy) begin
        busy_q.push_back(busy_len);
        busy_len = 0;
      end
      prev_busy = busy;
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pos[i] = 128;
      m_tgt[i] = 128;
    end
    m_ch = 0;
  endfunction

  // Expected position for channel m_ch at a strobe seen at cycle t.
  function automatic int model_step(int t);
    cap_t c;
    int d;
    while (cap_q.size() > 0 && cap_q[0].t < t) begin
      c = cap_q.pop_front();
      m_tgt[c.a] = (c.v < 25) ? 25 : (c.v > 230) ? 230 : c.v;
    end
    d = m_tgt[m_ch] - m_pos[m_ch];
`ifdef SERVO_SEQ_SLEW_BYPASS_EN
    m_pos[m_ch] = m_tgt[m_ch];
`else
    if (d > 4)       m_pos[m_ch] += 4;
    else if (d < -4) m_pos[m_ch] -= 4;
    else             m_pos[m_ch] = m_tgt[m_ch];
`endif
    return m_pos[m_ch];
  endfunction

  task automatic wait_frames(input int n);
    int goal = busy_q.size() + n;
    int k = 0;
    while (busy_q.size() < goal && k < n * 20 + 60) begin
      @(negedge clock);
      k++;
    end
    if (busy_q.size() < goal) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: got %0d frames, want %0d", busy_q.size(), goal);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!busy && k < 100) begin @(negedge clock); k++; end
    while (busy && k < 100) begin @(negedge clock); k++; end
    if (k >= 100) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, want 0", busy, k);
    end
  endtask

  task automatic press(input int a, input int d, input int hold);
    switch_address = 2'(a);
    switch_duty_cycle = 8'(d);
    key_load = 1'b0;
    cap_q.push_back('{cyc, a, d});
    repeat (hold) @(negedge clock);
    key_load = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++;
    if (load !== 1'b0 || busy !== 1'b0 || servo_address !== 2'd0 || duty_cycle !== 8'd128) begin
      bad++;
      $display("FAIL reset_state: got load=%0b busy=%0b addr=%0d duty=%0d, want 0 0 0 128",
               load, busy, servo_address, duty_cycle);
    end
    model_reset();
    reset = 1'b1;
    wait_frames(3);
    total++;
    if (sq.size() !== 12) begin
      bad++;
      $display("FAIL reset_strobe_count: got %0d, want 12", sq.size());
    end
    while (sq.size() > 0) begin
      strobe_t s;
      int e;
      s = sq.pop_front();
      e = model_step(s.t);
      total++;
      if (s.addr !== m_ch || s.duty !== e || (m_ch != 0 && s.gap !== 2)) begin
        bad++;
        $display("FAIL reset_frames: got addr=%0d duty=%0d gap=%0d, want addr=%0d duty=%0d gap=2",
                 s.addr, s.duty, s.gap, m_ch, e);
      end
      m_ch = (m_ch + 1) % 4;
    end
    while (busy_q.size() > 0) begin
      int b = busy_q.pop_front();
      total++;
      if (b !== 8) begin
        bad++;
        $display("FAIL busy_len: got %0d, want 8", b);
      end
    end
  endtask

  task automatic test_slew();
    wait_idle();
    press(2, 148, 10);
    wait_frames(7);
    wait_idle();
    press(3, 200, 10);
    wait_frames(2);
    while (sq.size() > 0) begin
      strobe_t s;
      int e;
      s = sq.pop_front();
      e = model_step(s.t);
      total++;
      if (s.addr !== m_ch || s.duty !== e || (m_ch != 0 && s.gap !== 2)) begin
        bad++;
        $display("FAIL slew: got addr=%0d duty=%0d gap=%0d, want addr=%0d duty=%0d gap=2",
                 s.addr, s.duty, s.gap, m_ch, e);
      end
      m_ch = (m_ch + 1) % 4;
    end
    while (busy_q.size() > 0) begin
      int b = busy_q.pop_front();
      total++;
      if (b !== 8) begin
        bad++;
        $display("FAIL slew_busy_len: got %0d, want 8", b);
      end
    end
  endtask

  task automatic test_clamp();
    int low = 255;
    wait_idle();
    press(0, 255, 10);
    wait_frames(3);
    wait_idle();
    press(0, 0, 10);
    wait_frames(35);
    wait_idle();
    press(1, 130, 10);
    wait_frames(2);
    while (sq.size() > 0) begin
      strobe_t s;
      int e;
      s = sq.pop_front();
      e = model_step(s.t);
      if (s.addr == 0 && s.duty < low) low = s.duty;
      total++;
      if (s.addr !== m_ch || s.duty !== e || (m_ch != 0 && s.gap !== 2)) begin
        bad++;
        $display("FAIL clamp: got addr=%0d duty=%0d gap=%0d, want addr=%0d duty=%0d gap=2",
                 s.addr, s.duty, s.gap, m_ch, e);
      end
      m_ch = (m_ch + 1) % 4;
    end
    total++;
    if (low !== 25) begin
      bad++;
      $display("FAIL clamp_floor: got lowest ch0 duty %0d, want 25", low);
    end
    busy_q.delete();
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      wait_idle();
      press(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 6 + int'($urandom_range(0, 6)));
      wait_frames(1 + int'($urandom_range(0, 3)));
    end
    while (sq.size() > 0) begin
      strobe_t s;
      int e;
      s = sq.pop_front();
      e = model_step(s.t);
      total++;
      if (s.addr !== m_ch || s.duty !== e || (m_ch != 0 && s.gap !== 2)) begin
        bad++;
        $display("FAIL random: got addr=%0d duty=%0d gap=%0d, want addr=%0d duty=%0d gap=2",
                 s.addr, s.duty, s.gap, m_ch, e);
      end
      m_ch = (m_ch + 1) % 4;
    end
    busy_q.delete();
  endtask

  task automatic test_glitch_and_hold();
    wait_idle();
    switch_address = 2'd1;
    switch_duty_cycle = 8'd40;
    for (int g = 1; g <= 4; g++) begin
      key_load = 1'b0;
      repeat (g) @(negedge clock);
      key_load = 1'b1;
      repeat (3) @(negedge clock);
    end
    wait_frames(2);
    wait_idle();
    switch_address = 2'd3;
    switch_duty_cycle = 8'd60;
    key_load = 1'b0;
    cap_q.push_back('{cyc, 3, 60});
    repeat (20) @(negedge clock);
    switch_address = 2'd1;
    switch_duty_cycle = 8'd200;
    repeat (180) @(negedge clock);
    key_load = 1'b1;
    wait_frames(4);
    while (sq.size() > 0) begin
      strobe_t s;
      int e;
      s = sq.pop_front();
      e = model_step(s.t);
      total++;
      if (s.addr !== m_ch || s.duty !== e || (m_ch != 0 && s.gap !== 2)) begin
        bad++;
        $display("FAIL glitch_hold: got addr=%0d duty=%0d gap=%0d, want addr=%0d duty=%0d gap=2",
                 s.addr, s.duty, s.gap, m_ch, e);
      end
      m_ch = (m_ch + 1) % 4;
    end
    busy_q.delete();
  endtask

  task automatic test_reset_mid_scan();
    int k = 0;
    @(negedge clock);
    while (!(load && servo_address == 2'd1) && k < 200) begin @(negedge clock); k++; end
    total++;
    if (k >= 200) begin
      bad++;
      $display("FAIL mid_scan_wait: no ch1 strobe within %0d cycles", k);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (load !== 1'b0 || duty_cycle !== 8'd128 || servo_address !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_scan_reset: got load=%0b duty=%0d addr=%0d busy=%0b, want 0 128 0 0",
               load, duty_cycle, servo_address, busy);
    end
    repeat (3) @(negedge clock);
    sq.delete();
    busy_q.delete();
    cap_q.delete();
    model_reset();
    last_strobe = cyc;
    reset = 1'b1;
    wait_frames(2);
    while (sq.size() > 0) begin
      strobe_t s;
      int e;
      s = sq.pop_front();
      e = model_step(s.t);
      total++;
      if (s.addr !== m_ch || s.duty !== e || (m_ch != 0 && s.gap !== 2)) begin
        bad++;
        $display("FAIL after_reset: got addr=%0d duty=%0d gap=%0d, want addr=%0d duty=%0d gap=2",
                 s.addr, s.duty, s.gap, m_ch, e);
      end
      m_ch = (m_ch + 1) % 4;
    end
    while (busy_q.size() > 0) begin
      int b = busy_q.pop_front();
      total++;
      if (b !== 8) begin
        bad++;
        $display("FAIL after_reset_busy_len: got %0d, want 8", b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_slew();
    test_clamp();
    test_random();
    test_glitch_and_hold();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
